// File: rtl/vector_cache_pkg.sv
// Shared types and constants for the vector cache read path.
package vector_cache_pkg;

    localparam int SECTOR_NUM    = 8;
    localparam int ROB_DEPTH_DEF = 8;
    localparam int TXN_ID_W      = 8;
    localparam int DATA_W        = 32;

    // One sector of a cache line as it leaves a bank row lane.
    typedef struct packed {
        logic [TXN_ID_W-1:0] txn_id;
        logic [DATA_W-1:0]   data;
    } data_pld_t;

endpackage

// File: rtl/vec_rd_data_rob_if.sv
// Allocation, sector-return and response signals of the read-data ROB.
interface vec_rd_data_rob_if #(
    parameter int ROB_DEPTH = vector_cache_pkg::ROB_DEPTH_DEF
) ();
    import vector_cache_pkg::*;

    localparam int IDX_W = $clog2(ROB_DEPTH);

    logic                         alloc_vld;
    logic                         alloc_rdy;
    logic [IDX_W-1:0]             alloc_id;
    logic [SECTOR_NUM-1:0]        data_in_vld;
    data_pld_t [SECTOR_NUM-1:0]   data_in;
    logic                         rsp_vld;
    logic                         rsp_rdy;
    logic [IDX_W-1:0]             rsp_id;
    data_pld_t [SECTOR_NUM-1:0]   rsp_data;
    logic [IDX_W:0]               occupancy;
    logic                         err_unexp;

    modport slave (
        input  alloc_vld, data_in_vld, data_in, rsp_rdy,
        output alloc_rdy, alloc_id, rsp_vld, rsp_id, rsp_data, occupancy, err_unexp
    );

    modport master (
        output alloc_vld, data_in_vld, data_in, rsp_rdy,
        input  alloc_rdy, alloc_id, rsp_vld, rsp_id, rsp_data, occupancy, err_unexp
    );

endinterface

// File: rtl/vec_rd_data_rob_slot.sv
// One ROB slot: valid flag, per-sector fill mask and the collected line.
// A lane write is accepted only into an allocated slot whose sector is still empty;
// anything else is reported on err for the cycle it arrives.
module vec_rob_slot
    import vector_cache_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc,
    input  logic                       retire,
    input  logic [SECTOR_NUM-1:0]      lane_we,
    input  data_pld_t [SECTOR_NUM-1:0] lane_data,
    output logic                       valid,
    output logic                       complete,
    output data_pld_t [SECTOR_NUM-1:0] line,
    output logic                       err
);

    logic [SECTOR_NUM-1:0] mask;
    logic [SECTOR_NUM-1:0] lane_ok;

    assign lane_ok  = lane_we & ~mask & {SECTOR_NUM{valid}};
    assign err      = |(lane_we & ~lane_ok);
    assign complete = &mask;

    // Slot ownership; a new allocation wins over a retire on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (alloc) begin
            valid <= 1'b1;
        end else if (retire) begin
            valid <= 1'b0;
        end
    end

    // Sector fill mask, emptied whenever the slot is handed out again.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '0;
        end else if (alloc) begin
            mask <= '0;
        end else begin
            mask <= mask | lane_ok;
        end
    end

    // Line storage; contents are only meaningful where the mask is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SECTOR_NUM; i++) begin
            if (lane_ok[i]) begin
                line[i] <= lane_data[i];
            end
        end
    end

endmodule

// File: rtl/vec_rd_data_rob.sv
// Read-data reorder buffer behind the west edge of an SRAM bank row.
// Slots are granted in order, filled by sector from any lane in any order,
// and retired strictly in allocation order once the head line is complete.
module vec_rd_data_rob
    import vector_cache_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    vec_rd_data_rob_if.slave bus
);

    localparam int IDX_W = $clog2(ROB_DEPTH);
    localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(ROB_DEPTH);

    logic [IDX_W-1:0]           head;
    logic [IDX_W-1:0]           tail;
    logic [IDX_W:0]             count;
    logic                       alloc_rdy;
    logic                       rsp_vld;
    logic                       alloc_fire;
    logic                       retire_fire;
    logic                       err_unexp;

    logic [ROB_DEPTH-1:0]       slot_valid;
    logic [ROB_DEPTH-1:0]       slot_complete;
    logic [ROB_DEPTH-1:0]       slot_err;
    logic [ROB_DEPTH-1:0]       slot_alloc;
    logic [ROB_DEPTH-1:0]       slot_retire;
    logic [SECTOR_NUM-1:0]      slot_we   [ROB_DEPTH];
    data_pld_t [SECTOR_NUM-1:0] slot_line [ROB_DEPTH];

    // No bypass from a same-cycle retire: readiness looks only at the registered count.
    assign alloc_rdy   = (count < DEPTH_CNT);
    assign alloc_fire  = bus.alloc_vld & alloc_rdy;
    assign rsp_vld     = slot_valid[head] & slot_complete[head];
    assign retire_fire = rsp_vld & bus.rsp_rdy;

    assign bus.alloc_rdy = alloc_rdy;
    assign bus.alloc_id  = tail;
    assign bus.rsp_vld   = rsp_vld;
    assign bus.rsp_id    = head;
    assign bus.rsp_data  = slot_line[head];
    assign bus.occupancy = count;
    assign bus.err_unexp = err_unexp;

    // Steer each lane's sector to the slot named by the low bits of its txn_id.
    always_comb begin
        for (int j = 0; j < ROB_DEPTH; j++) begin
            slot_we[j] = '0;
            for (int i = 0; i < SECTOR_NUM; i++) begin
                slot_we[j][i] = bus.data_in_vld[i] &&
                                (bus.data_in[i].txn_id[IDX_W-1:0] == IDX_W'(j));
            end
        end
    end

    for (genvar g = 0; g < ROB_DEPTH; g++) begin : g_slot
        assign slot_alloc[g]  = alloc_fire  & (tail == IDX_W'(g));
        assign slot_retire[g] = retire_fire & (head == IDX_W'(g));

        vec_rob_slot u_slot (
            .clk      (clk),
            .rst      (rst),
            .alloc    (slot_alloc[g]),
            .retire   (slot_retire[g]),
            .lane_we  (slot_we[g]),
            .lane_data(bus.data_in),
            .valid    (slot_valid[g]),
            .complete (slot_complete[g]),
            .line     (slot_line[g]),
            .err      (slot_err[g])
        );
    end

    // Ring pointers and occupancy; alloc and retire together leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire) begin
                tail <= tail + 1'b1;
            end
            if (retire_fire) begin
                head <= head + 1'b1;
            end
            case ({alloc_fire, retire_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flag for any dropped sector (unallocated slot or duplicate lane).
    always_ff @(posedge clk) begin
        if (rst) begin
            err_unexp <= 1'b0;
        end else if (|slot_err) begin
            err_unexp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vec_rd_data_rob.sv
// Self-checking bench for vec_rd_data_rob: directed table, corner sequences,
// and a randomized run against an in-order queue model of the ROB.
module tb_vec_rd_data_rob;
    import vector_cache_pkg::*;

    localparam int D = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vec_rd_data_rob_if #(.ROB_DEPTH(D)) bus ();

    vec_rd_data_rob #(.ROB_DEPTH(D)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: allocated slot ids in allocation order, per-slot masks and data.
    int        q[$];
    logic [7:0] m_mask [D];
    data_pld_t  m_data [D][SECTOR_NUM];
    bit         m_err;
    int         m_allocs;

    typedef struct {
        bit         alloc;
        bit         rdy;
        logic [7:0] lv;
        int         slot;
        bit         e_rdy;
        int         e_id;
        int         e_occ;
        bit         e_rv;
        int         e_rid;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit a, bit r, logic [7:0] lv, int s,
                                bit er, int eid, int eocc, bit erv, int erid);
        vec_t v;
        v.alloc = a; v.rdy = r; v.lv = lv; v.slot = s;
        v.e_rdy = er; v.e_id = eid; v.e_occ = eocc; v.e_rv = erv; v.e_rid = erid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_q(int s);
        foreach (q[k]) if (q[k] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_rsp_vld();
        return (q.size() > 0) && (m_mask[q[0]] == 8'hFF);
    endfunction

    function automatic int m_head();
        return (q.size() > 0) ? q[0] : (m_allocs % D);
    endfunction

    task automatic model_reset();
        q.delete();
        for (int s = 0; s < D; s++) m_mask[s] = '0;
        m_err    = 1'b0;
        m_allocs = 0;
    endtask

    task automatic model_update();
        bit a_f;
        bit r_f;
        int s;
        if (rst) begin
            model_reset();
            return;
        end
        a_f = bus.alloc_vld && (q.size() < D);
        r_f = bus.rsp_rdy && m_rsp_vld();
        for (int i = 0; i < SECTOR_NUM; i++) begin
            if (bus.data_in_vld[i]) begin
                s = int'(bus.data_in[i].txn_id[2:0]);
                if (in_q(s) && !m_mask[s][i]) begin
                    m_mask[s][i] = 1'b1;
                    m_data[s][i] = bus.data_in[i];
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        if (r_f) void'(q.pop_front());
        if (a_f) begin
            q.push_back(m_allocs % D);
            m_mask[m_allocs % D] = '0;
            m_allocs++;
        end
    endtask

    task automatic check_model();
        chk("alloc_rdy", bus.alloc_rdy, (q.size() < D));
        chk("alloc_id",  bus.alloc_id,  m_allocs % D);
        chk("occupancy", bus.occupancy, q.size());
        chk("rsp_vld",   bus.rsp_vld,   m_rsp_vld());
        chk("rsp_id",    bus.rsp_id,    m_head());
        chk("err_unexp", bus.err_unexp, m_err);
        if (m_rsp_vld())
            for (int i = 0; i < SECTOR_NUM; i++)
                chk("rsp_data", bus.rsp_data[i], m_data[q[0]][i]);
    endtask

    task automatic step();
        check_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.alloc_vld   = 1'b0;
        bus.rsp_rdy     = 1'b0;
        bus.data_in_vld = '0;
    endtask

    task automatic lanes(input int slot, input logic [7:0] vld, input int base);
        for (int i = 0; i < SECTOR_NUM; i++) begin
            if (vld[i]) begin
                bus.data_in[i].txn_id = 8'(slot);
                bus.data_in[i].data   = 32'(base + i * 16 + 1);
            end
        end
        bus.data_in_vld = vld;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst = 1'b1;
        idle();
        bus.data_in = '0;
        @(negedge clk);
        do_reset();

        // Fill to full, then complete slot 0 in two halves and retire it.
        for (int k = 0; k < 8; k++) tbl.push_back(mk(1, 0, 8'h00, 0, 1, k, k, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8, 0, 0));
        tbl.push_back(mk(0, 0, 8'h0F, 0, 0, 0, 8, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8, 0, 0));
        tbl.push_back(mk(0, 0, 8'hF0, 0, 0, 0, 8, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8, 1, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 8, 1, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 7, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8, 0, 1));

        for (int k = 0; k < tbl.size(); k++) begin
            chk("tbl_alloc_rdy", bus.alloc_rdy, tbl[k].e_rdy);
            chk("tbl_alloc_id",  bus.alloc_id,  tbl[k].e_id);
            chk("tbl_occupancy", bus.occupancy, tbl[k].e_occ);
            chk("tbl_rsp_vld",   bus.rsp_vld,   tbl[k].e_rv);
            chk("tbl_rsp_id",    bus.rsp_id,    tbl[k].e_rid);
            if (k == 12) chk("tbl_lane5_data", bus.rsp_data[5].data, 32'h51);
            bus.alloc_vld = tbl[k].alloc;
            bus.rsp_rdy   = tbl[k].rdy;
            lanes(tbl[k].slot, tbl[k].lv, 0);
            step();
        end

        // Younger slot completes first; head must gate retirement.
        do_reset();
        bus.alloc_vld = 1'b1; step(); step();
        idle(); lanes(1, 8'hFF, 32'h100); step();
        idle();
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold", bus.rsp_vld, 1'b0);
            step();
        end
        lanes(0, 8'hFF, 32'h200); step();
        idle(); bus.rsp_rdy = 1'b1;
        chk("t3_vld0", bus.rsp_vld, 1'b1);
        chk("t3_id0",  bus.rsp_id,  0);
        step();
        chk("t3_vld1", bus.rsp_vld, 1'b1);
        chk("t3_id1",  bus.rsp_id,  1);
        chk("t3_data1", bus.rsp_data[3].data, 32'h100 + 3 * 16 + 1);
        step();
        chk("t3_empty", bus.rsp_vld, 1'b0);
        chk("t3_occ",   bus.occupancy, 0);

        // Full ROB: a same-cycle retire does not open an allocation.
        do_reset();
        bus.alloc_vld = 1'b1;
        for (int k = 0; k < 8; k++) step();
        idle(); lanes(0, 8'hFF, 32'h300); step();
        idle(); bus.alloc_vld = 1'b1; bus.rsp_rdy = 1'b1;
        chk("t4_full_rdy", bus.alloc_rdy, 1'b0);
        chk("t4_full_vld", bus.rsp_vld, 1'b1);
        step();
        bus.rsp_rdy = 1'b0;
        chk("t4_wrap_id",  bus.alloc_id, 0);
        chk("t4_wrap_rdy", bus.alloc_rdy, 1'b1);
        chk("t4_wrap_occ", bus.occupancy, 7);
        step();
        idle();
        chk("t4_refull_occ", bus.occupancy, 8);
        chk("t4_refull_rdy", bus.alloc_rdy, 1'b0);

        // Unexpected sectors: unallocated slot, then a duplicate lane.
        do_reset();
        bus.alloc_vld = 1'b1; step(); step();
        idle(); lanes(0, 8'h04, 32'h400); step();
        idle();
        chk("t5_clean", bus.err_unexp, 1'b0);
        lanes(3, 8'h01, 32'h500); step();
        idle();
        chk("t5_unalloc", bus.err_unexp, 1'b1);
        lanes(0, 8'h04, 32'h600); step();
        idle(); lanes(0, 8'hFB, 32'h400); step();
        idle();
        chk("t5_line_vld", bus.rsp_vld, 1'b1);
        chk("t5_dup_kept", bus.rsp_data[2].data, 32'h421);
        for (int k = 0; k < 4; k++) step();
        chk("t5_sticky", bus.err_unexp, 1'b1);

        // Sector aimed at the slot being allocated in the same cycle is dropped.
        do_reset();
        bus.alloc_vld = 1'b1; lanes(0, 8'h01, 32'h700); step();
        idle();
        chk("t5_same_cycle", bus.err_unexp, 1'b1);
        chk("t5_same_occ",   bus.occupancy, 1);

        // Reset with partially filled slots discards them.
        do_reset();
        bus.alloc_vld = 1'b1;
        for (int k = 0; k < 4; k++) step();
        idle();
        for (int k = 0; k < 4; k++) begin
            lanes(k, 8'h0F, 32'h800 + k * 256); step();
        end
        lanes(7, 8'h01, 32'h900); step();
        idle();
        rst = 1'b1; step(); rst = 1'b0;
        chk("t6_occ",   bus.occupancy, 0);
        chk("t6_vld",   bus.rsp_vld,   1'b0);
        chk("t6_id",    bus.alloc_id,  0);
        chk("t6_err",   bus.err_unexp, 1'b0);
        chk("t6_rdy",   bus.alloc_rdy, 1'b1);
        lanes(1, 8'h10, 32'hA00); step();
        idle();
        chk("t6_stale", bus.err_unexp, 1'b1);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 999) == 0);
            bus.alloc_vld = ($urandom_range(0, 99) < 60);
            bus.rsp_rdy   = ($urandom_range(0, 99) < 50);
            bus.data_in_vld = '0;
            for (int i = 0; i < SECTOR_NUM; i++) begin
                s = -1;
                if (q.size() > 0 && $urandom_range(0, 99) < 40) begin
                    s = q[$urandom_range(0, q.size() - 1)];
                    if (m_mask[s][i]) s = -1;
                end
                if (n >= 2500 && $urandom_range(0, 99) < 3) s = $urandom_range(0, D - 1);
                if (s >= 0) begin
                    bus.data_in[i].txn_id = {5'($urandom), 3'(s)};
                    bus.data_in[i].data   = $urandom;
                    bus.data_in_vld[i]    = 1'b1;
                end
            end
            step();
        end
        rst = 1'b0;
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
